// File: rtl/uart_rx_deser_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the majority vote.
package uart_rx_deser_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_e;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deser_baud_tick.sv
// Free-running oversample tick divider; restart realigns it to a detected start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 2-FF synchronizer, oversampled 2-of-3 majority, MSB-first 8N1 deserializer.
module uart_rx_deser
  import uart_rx_deser_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_PRE  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_DEC  = SW'(M + 1);

  logic       sync1, rxs;
  logic [1:0] warm;
  logic       armed;
  rx_state_e  state;
  logic [SW-1:0] s;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       smp_a, smp_b;
  logic       tick, restart, decide, bit_v;

  // Synchronizer reset values are not real line samples, so the start detector
  // only arms once a genuine high level has passed through both flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= rx_serial;
      rxs   <= sync1;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & rxs);
    end
  end

  assign restart = (state == S_IDLE) && armed && !rxs;
  assign decide  = tick && (s == S_DEC);
  assign bit_v   = maj3(smp_a, smp_b, rxs);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      s          <= '0;
      idx        <= '0;
      shreg      <= '0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      data_byte  <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tick && state != S_IDLE && state != S_BREAK)
        s <= (s == S_LAST) ? '0 : s + 1'b1;
      if (tick && s == S_PRE) smp_a <= rxs;
      if (tick && s == S_MID) smp_b <= rxs;
      case (state)
        S_IDLE: if (restart) begin
          state <= S_START;
          s     <= '0;
          busy  <= 1'b1;
        end
        S_START: if (decide) begin
          if (bit_v == UART_START_BIT) begin
            state <= S_DATA;
            idx   <= 3'(UART_DATA_BITS - 1);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_DATA: if (decide) begin
          shreg <= {shreg[6:0], bit_v};
          if (idx == 3'd0) state <= S_STOP;
          else             idx   <= idx - 1'b1;
        end
        S_STOP: if (decide) begin
          if (bit_v == UART_STOP_BIT) begin
            data_byte  <= shreg;
            data_valid <= 1'b1;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end
        end
        S_BREAK: if (rxs) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser at DIV=1 (one bit = 16 clks).
module tb_uart_rx_deser;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_byte;
  logic       data_valid, frame_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_seen = 0;
  logic [7:0] exp_q[$];

  uart_rx_deser #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (rst),
    .rx_serial  (rx),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic line(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    line(1'b0, BIT);
    for (int i = 7; i >= 0; i--) line(b[i], BIT);
    line(stop, BIT);
  endtask

  // Each data bit carries a one-clock opposite-value spike near mid-bit.
  task automatic send_spiked(input logic [7:0] b);
    exp_q.push_back(b);
    line(1'b0, BIT);
    for (int i = 7; i >= 0; i--) begin
      line(b[i], 7);
      line(~b[i], 1);
      line(b[i], 8);
    end
    line(1'b1, BIT);
  endtask

  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      if (data_valid && frame_err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_overlap: data_valid=1 frame_err=1, expected never both");
      end
      if (frame_err) fe_seen++;
      if (data_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_byte: got %h, expected no data_valid", data_byte);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (data_byte !== e) begin
            n_bad++;
            $display("FAIL rx_byte: got %h, expected %h", data_byte, e);
          end
        end
      end
    end
  end

  initial begin
    int fe0;
    // Line held low across reset release must not start a frame.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_data_byte", data_byte, 8'h00);
    check("reset_valid", {7'd0, data_valid}, 8'd0);
    check("reset_frame_err", {7'd0, frame_err}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    repeat (40) @(negedge clk);
    check("low_after_reset_busy", {7'd0, busy}, 8'd0);
    line(1'b1, 3 * BIT);

    send_frame(8'hA5, 1'b1);
    line(1'b1, 2 * BIT);
    check("a5_data_byte", data_byte, 8'hA5);
    check("a5_no_frame_err", fe_seen[7:0], 8'd0);

    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    line(1'b1, 2 * BIT);
    check("b2b_last_byte", data_byte, 8'hC3);

    // Short low glitch on an idle line.
    line(1'b0, 4);
    line(1'b1, 40);
    check("glitch_busy", {7'd0, busy}, 8'd0);
    check("glitch_frame_err", fe_seen[7:0], 8'd0);
    check("glitch_data_byte", data_byte, 8'hC3);

    send_spiked(8'hF0);
    line(1'b1, 2 * BIT);
    check("spike_data_byte", data_byte, 8'hF0);

    // Bad stop bit, then a long break.
    fe0 = fe_seen;
    send_frame(8'h81, 1'b0);
    check("break_busy", {7'd0, busy}, 8'd1);
    line(1'b0, 30 * BIT);
    line(1'b1, 2 * BIT);
    check("break_fe_count", 8'(fe_seen - fe0), 8'd1);
    check("break_data_byte", data_byte, 8'hF0);
    check("break_busy_after", {7'd0, busy}, 8'd0);
    send_frame(8'h55, 1'b1);
    line(1'b1, 2 * BIT);
    check("after_break_byte", data_byte, 8'h55);

    // Reset in the middle of data bit index 3.
    line(1'b0, BIT);
    line(1'b1, BIT); line(1'b0, BIT); line(1'b1, BIT); line(1'b0, BIT);
    line(1'b1, 8);
    check("mid_frame_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    check("abort_data_byte", data_byte, 8'h00);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_valid", {7'd0, data_valid}, 8'd0);
    check("abort_frame_err", {7'd0, frame_err}, 8'd0);
    @(negedge clk);
    line(1'b1, 5);
    rst = 1'b0;
    line(1'b1, 2 * BIT);
    send_frame(8'h0F, 1'b1);
    line(1'b1, 3 * BIT);
    check("post_reset_byte", data_byte, 8'h0F);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    check("total_frame_err", fe_seen[7:0], 8'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
